// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period tokens and the
// alignment-controller state encoding.
package tmds_pkg;

  localparam logic [9:0] CTL_TOK0 = 10'h0AB;
  localparam logic [9:0] CTL_TOK1 = 10'h354;
  localparam logic [9:0] CTL_TOK2 = 10'h0AA;
  localparam logic [9:0] CTL_TOK3 = 10'h355;

  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } align_state_e;

  function automatic logic is_ctl_token(input logic [9:0] w);
    return (w == CTL_TOK0) || (w == CTL_TOK1) ||
           (w == CTL_TOK2) || (w == CTL_TOK3);
  endfunction

endpackage

// File: rtl/tmds_ctl_detect.sv
// Control-token matcher and run counter; o_run_hit fires once
// on the word that completes a run of CTL_RUN tokens.
module tmds_ctl_detect
  import tmds_pkg::*;
#(
  parameter int CTL_RUN = 8
) (
  input  logic       i_clk,
  input  logic       i_areset_n,
  input  logic       i_ce,
  input  logic [9:0] i_word,
  input  logic       i_clr,
  output logic       o_run_hit
);

  localparam int RW = $clog2(CTL_RUN + 1);

  logic [RW-1:0] run_q, run_d;
  logic          tok;

  always_comb begin
    tok       = is_ctl_token(i_word);
    run_d     = run_q;
    o_run_hit = 1'b0;
    if (i_clr) begin
      run_d = '0;
    end else if (i_ce) begin
      if (!tok) begin
        run_d = '0;
      end else if (run_q != RW'(CTL_RUN)) begin
        run_d     = run_q + 1'b1;
        o_run_hit = (run_q == RW'(CTL_RUN - 1));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) run_q <= '0;
    else             run_q <= run_d;
  end

endmodule

// File: rtl/tmds_align_ctrl.sv
// TMDS word-alignment controller: hunts for blanking runs,
// bit-slips the deserializer until aligned, and tracks lock.
module tmds_align_ctrl
  import tmds_pkg::*;
#(
  parameter int CTL_RUN   = 8,
  parameter int LGSEARCH  = 20,
  parameter int SETTLE    = 16,
  parameter int LGTIMEOUT = 22
) (
  input  logic       i_clk,
  input  logic       i_areset_n,
  input  logic       i_ce,
  input  logic [9:0] i_word,
  input  logic       i_relock,
  output logic       o_slip,
  output logic       o_locked,
  output logic [3:0] o_slip_count,
  output logic       o_lock_lost
);

  localparam int SW = $clog2(SETTLE + 1);

  align_state_e         state_q, state_d;
  logic [LGSEARCH-1:0]  win_q, win_d;
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
  logic [SW-1:0]        stl_q, stl_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 slip_q, locked_q, lost_q;
  logic                 run_hit, win_wrap, tmo_wrap;
  logic                 chg, det_clr;

  assign det_clr = i_relock || (state_q == ST_SETTLE);

  tmds_ctl_detect #(.CTL_RUN(CTL_RUN)) u_det (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_ce       (i_ce),
    .i_word     (i_word),
    .i_clr      (det_clr),
    .o_run_hit  (run_hit)
  );

  always_comb begin
    state_d  = state_q;
    win_wrap = i_ce && (&win_q);
    tmo_wrap = i_ce && (&tmo_q);
    unique case (state_q)
      ST_SEARCH: begin
        if (run_hit)       state_d = ST_VERIFY;
        else if (win_wrap) state_d = ST_SLIP;
      end
      ST_VERIFY: begin
        if (run_hit)       state_d = ST_LOCKED;
        else if (win_wrap) state_d = ST_SLIP;
      end
      ST_SLIP:   state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (stl_q == SW'(SETTLE - 1)) state_d = ST_SEARCH;
      end
      ST_LOCKED: begin
        if (tmo_wrap) state_d = ST_SEARCH;
      end
      default:   state_d = ST_SEARCH;
    endcase
    if (i_relock) state_d = ST_SEARCH;

    chg = i_relock || (state_d != state_q);

    win_d = win_q;
    if (chg || run_hit ||
        !((state_q == ST_SEARCH) || (state_q == ST_VERIFY)))
      win_d = '0;
    else if (i_ce)
      win_d = win_q + 1'b1;

    tmo_d = tmo_q;
    if (chg || run_hit || (state_q != ST_LOCKED))
      tmo_d = '0;
    else if (i_ce)
      tmo_d = tmo_q + 1'b1;

    stl_d = '0;
    if (!chg && (state_q == ST_SETTLE))
      stl_d = stl_q + 1'b1;

    // slip offset mirrors the deserializer, so relock keeps it
    cnt_d = cnt_q;
    if ((state_d == ST_SLIP) && (state_q != ST_SLIP))
      cnt_d = (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q  <= ST_SEARCH;
      win_q    <= '0;
      tmo_q    <= '0;
      stl_q    <= '0;
      cnt_q    <= '0;
      slip_q   <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      tmo_q    <= tmo_d;
      stl_q    <= stl_d;
      cnt_q    <= cnt_d;
      slip_q   <= (state_d == ST_SLIP) && (state_q != ST_SLIP);
      locked_q <= (state_d == ST_LOCKED);
      lost_q   <= (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
    end
  end

  assign o_slip       = slip_q;
  assign o_locked     = locked_q;
  assign o_slip_count = cnt_q;
  assign o_lock_lost  = lost_q;

endmodule
